// File: rtl/calc_operand_entry.sv
// Keypad-to-operand sequencer: assembles two decimal-entered operands and an
// operator from single key strobes, and pulses exec_pulse on "=".
module calc_operand_entry #(
    parameter int WIDTH      = 8,
    parameter int MAX_DIGITS = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_valid,
    input  logic [7:0]       key_code,
    input  logic [WIDTH-1:0] mem_value,
    input  logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] operand_a,
    output logic [WIDTH-1:0] operand_b,
    output logic [1:0]       op_code,
    output logic             sel_operand,
    output logic [1:0]       digit_count,
    output logic             exec_pulse,
    output logic             overflow_err
);

    typedef enum logic [1:0] {ENTER_A, ENTER_B, DONE} state_t;

    localparam logic [1:0] MAXD = 2'(MAX_DIGITS);

    state_t           state, state_n;
    logic [WIDTH-1:0] a_n, b_n;
    logic [1:0]       op_n, cnt_n;
    logic             sel_n, pulse_n, ovf_n;
    logic             lock_a, lock_b, la_n, lb_n;

    logic [WIDTH-1:0] cur;
    logic             cur_lock;
    logic [WIDTH+3:0] nxt;
    logic [1:0]       op_sel;
    logic             is_digit, is_op, b_started;

    always_comb begin
        state_n  = state;
        a_n      = operand_a;
        b_n      = operand_b;
        op_n     = op_code;
        cnt_n    = digit_count;
        pulse_n  = 1'b0;
        ovf_n    = overflow_err;
        la_n     = lock_a;
        lb_n     = lock_b;

        cur       = (state == ENTER_B) ? operand_b : operand_a;
        cur_lock  = (state == ENTER_B) ? lock_b : lock_a;
        nxt       = {4'b0, cur} * (WIDTH+4)'(10) + (WIDTH+4)'(key_code[3:0]);
        op_sel    = 2'(key_code - 8'h0A);
        is_digit  = (key_code <= 8'h09);
        is_op     = (key_code >= 8'h0A) && (key_code <= 8'h0D);
        b_started = (digit_count != 2'd0) || lock_b;

        if (key_valid) begin
            if (key_code == 8'h0F) begin
                state_n = ENTER_A;
                a_n     = '0;
                b_n     = '0;
                op_n    = '0;
                cnt_n   = '0;
                ovf_n   = 1'b0;
                la_n    = 1'b0;
                lb_n    = 1'b0;
            end else if (is_digit) begin
                if (state == DONE) begin
                    state_n = ENTER_A;
                    a_n     = WIDTH'(key_code[3:0]);
                    b_n     = '0;
                    cnt_n   = 2'd1;
                    ovf_n   = 1'b0;
                    la_n    = 1'b0;
                    lb_n    = 1'b0;
                end else if (digit_count == MAXD || cur_lock || nxt[WIDTH+3:WIDTH] != '0) begin
                    ovf_n = 1'b1;
                end else begin
                    if (state == ENTER_B) b_n = nxt[WIDTH-1:0];
                    else                  a_n = nxt[WIDTH-1:0];
                    cnt_n = digit_count + 2'd1;
                end
            end else if (is_op) begin
                case (state)
                    ENTER_A: begin
                        op_n    = op_sel;
                        b_n     = '0;
                        lb_n    = 1'b0;
                        cnt_n   = '0;
                        state_n = ENTER_B;
                    end
                    ENTER_B: begin
                        if (!b_started) op_n = op_sel;
                    end
                    default: begin
                        // Chaining: the previous ALU result becomes the new A.
                        a_n     = result;
                        la_n    = 1'b0;
                        op_n    = op_sel;
                        b_n     = '0;
                        lb_n    = 1'b0;
                        cnt_n   = '0;
                        state_n = ENTER_B;
                    end
                endcase
            end else if (key_code == 8'h0E) begin
                if (state == ENTER_B && b_started) begin
                    pulse_n = 1'b1;
                    state_n = DONE;
                end
            end else if (key_code == 8'h10) begin
                case (state)
                    ENTER_A: begin
                        a_n  = mem_value;
                        la_n = 1'b1;
                    end
                    ENTER_B: begin
                        b_n  = mem_value;
                        lb_n = 1'b1;
                    end
                    default: begin
                        a_n     = mem_value;
                        la_n    = 1'b1;
                        b_n     = '0;
                        lb_n    = 1'b0;
                        cnt_n   = '0;
                        ovf_n   = 1'b0;
                        state_n = ENTER_A;
                    end
                endcase
            end
        end

        sel_n = (state_n == ENTER_B);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ENTER_A;
            operand_a    <= '0;
            operand_b    <= '0;
            op_code      <= '0;
            sel_operand  <= 1'b0;
            digit_count  <= '0;
            exec_pulse   <= 1'b0;
            overflow_err <= 1'b0;
            lock_a       <= 1'b0;
            lock_b       <= 1'b0;
        end else begin
            state        <= state_n;
            operand_a    <= a_n;
            operand_b    <= b_n;
            op_code      <= op_n;
            sel_operand  <= sel_n;
            digit_count  <= cnt_n;
            exec_pulse   <= pulse_n;
            overflow_err <= ovf_n;
            lock_a       <= la_n;
            lock_b       <= lb_n;
        end
    end

endmodule

// File: tb/tb_calc_operand_entry.sv
// Bench for calc_operand_entry: directed scenarios plus random key streams
// checked against a behavioural model of the key rules.
module tb_calc_operand_entry;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             key_valid = 1'b0;
    logic [7:0]       key_code = '0;
    logic [WIDTH-1:0] mem_value = '0;
    logic [WIDTH-1:0] result = '0;
    logic [WIDTH-1:0] operand_a, operand_b;
    logic [1:0]       op_code, digit_count;
    logic             sel_operand, exec_pulse, overflow_err;

    int errors = 0;
    int checks = 0;

    // Model state: phase 0 = entering A, 1 = entering B, 2 = done.
    int m_phase, m_a, m_b, m_op, m_cnt;
    bit m_pulse, m_ovf, m_la, m_lb;

    calc_operand_entry #(.WIDTH(WIDTH), .MAX_DIGITS(3)) dut (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
        .mem_value(mem_value), .result(result), .operand_a(operand_a),
        .operand_b(operand_b), .op_code(op_code), .sel_operand(sel_operand),
        .digit_count(digit_count), .exec_pulse(exec_pulse), .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    task automatic model_step(input bit r, input bit kv, input int k);
        int val;
        m_pulse = 0;
        if (!r || (kv && k == 15)) begin
            m_phase = 0; m_a = 0; m_b = 0; m_op = 0; m_cnt = 0;
            m_ovf = 0; m_la = 0; m_lb = 0;
        end else if (kv) begin
            if (k <= 9) begin
                if (m_phase == 2) begin
                    m_a = k; m_b = 0; m_cnt = 1; m_ovf = 0; m_la = 0; m_lb = 0; m_phase = 0;
                end else begin
                    val = ((m_phase == 1) ? m_b : m_a) * 10 + k;
                    if (m_cnt == 3 || (m_phase == 1 ? m_lb : m_la) || val > 255) m_ovf = 1;
                    else begin
                        if (m_phase == 1) m_b = val; else m_a = val;
                        m_cnt++;
                    end
                end
            end else if (k >= 10 && k <= 13) begin
                if (m_phase == 0) begin
                    m_op = k - 10; m_b = 0; m_lb = 0; m_cnt = 0; m_phase = 1;
                end else if (m_phase == 1) begin
                    if (m_cnt == 0 && !m_lb) m_op = k - 10;
                end else begin
                    m_a = int'(result); m_la = 0; m_op = k - 10; m_b = 0; m_lb = 0;
                    m_cnt = 0; m_phase = 1;
                end
            end else if (k == 14) begin
                if (m_phase == 1 && (m_cnt > 0 || m_lb)) begin
                    m_pulse = 1; m_phase = 2;
                end
            end else if (k == 16) begin
                if (m_phase == 0) begin
                    m_a = int'(mem_value); m_la = 1;
                end else if (m_phase == 1) begin
                    m_b = int'(mem_value); m_lb = 1;
                end else begin
                    m_a = int'(mem_value); m_la = 1; m_b = 0; m_lb = 0;
                    m_cnt = 0; m_ovf = 0; m_phase = 0;
                end
            end
        end
    endtask

    task automatic cycle(input bit r, input bit kv, input logic [7:0] k);
        @(negedge clk);
        rst_n = r; key_valid = kv; key_code = k;
        @(posedge clk);
        model_step(r, kv, int'(k));
        #1;
        rst_n = 1'b1; key_valid = 1'b0;
    endtask

    task automatic press(input logic [7:0] k);
        cycle(1'b1, 1'b1, k);
    endtask

    task automatic test_reset();
        cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 8'h05);
        checks++;
        if ({operand_a, operand_b, op_code, sel_operand, digit_count, exec_pulse, overflow_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got a=%0d b=%0d op=%0d sel=%0b cnt=%0d pulse=%0b ovf=%0b, expected all 0",
                     operand_a, operand_b, op_code, sel_operand, digit_count, exec_pulse, overflow_err);
        end
    endtask

    task automatic test_digits();
        press(8'h0F); press(8'h01); press(8'h02); press(8'h03);
        checks++;
        if (operand_a !== 8'd123 || digit_count !== 2'd3 || sel_operand !== 1'b0 || overflow_err !== 1'b0) begin
            errors++;
            $display("FAIL digits_123: got a=%0d cnt=%0d sel=%0b ovf=%0b, expected a=123 cnt=3 sel=0 ovf=0",
                     operand_a, digit_count, sel_operand, overflow_err);
        end
        press(8'h04);
        checks++;
        if (operand_a !== 8'd123 || digit_count !== 2'd3 || overflow_err !== 1'b1) begin
            errors++;
            $display("FAIL fourth_digit: got a=%0d cnt=%0d ovf=%0b, expected a=123 cnt=3 ovf=1",
                     operand_a, digit_count, overflow_err);
        end
    endtask

    task automatic test_overflow();
        press(8'h0F); press(8'h02); press(8'h05); press(8'h06);
        checks++;
        if (operand_a !== 8'd25 || digit_count !== 2'd2 || overflow_err !== 1'b1) begin
            errors++;
            $display("FAIL overflow_256: got a=%0d cnt=%0d ovf=%0b, expected a=25 cnt=2 ovf=1",
                     operand_a, digit_count, overflow_err);
        end
        press(8'h11);
        checks++;
        if (overflow_err !== 1'b1 || operand_a !== 8'd25) begin
            errors++;
            $display("FAIL sticky_ovf: got a=%0d ovf=%0b, expected a=25 ovf=1", operand_a, overflow_err);
        end
    endtask

    task automatic test_add_equals();
        int pulses = 0;
        press(8'h0F);
        press(8'h07); pulses += int'(exec_pulse);
        press(8'h0A); pulses += int'(exec_pulse);
        checks++;
        if (sel_operand !== 1'b1 || operand_b !== 8'd0) begin
            errors++;
            $display("FAIL enter_b: got sel=%0b b=%0d, expected sel=1 b=0", sel_operand, operand_b);
        end
        press(8'h08); pulses += int'(exec_pulse);
        press(8'h0E); pulses += int'(exec_pulse);
        checks++;
        if (operand_a !== 8'd7 || operand_b !== 8'd8 || op_code !== 2'b00 || exec_pulse !== 1'b1 || sel_operand !== 1'b0) begin
            errors++;
            $display("FAIL add_equals: got a=%0d b=%0d op=%0d pulse=%0b sel=%0b, expected a=7 b=8 op=0 pulse=1 sel=0",
                     operand_a, operand_b, op_code, exec_pulse, sel_operand);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 8'h0E);
            pulses += int'(exec_pulse);
        end
        press(8'h0E); pulses += int'(exec_pulse);
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL pulse_count: got %0d exec pulses, expected 1", pulses);
        end
    endtask

    task automatic test_chaining();
        result = 8'd15;
        press(8'h0B); press(8'h03); press(8'h0E);
        checks++;
        if (operand_a !== 8'd15 || op_code !== 2'b01 || operand_b !== 8'd3 || exec_pulse !== 1'b1) begin
            errors++;
            $display("FAIL chaining: got a=%0d op=%0d b=%0d pulse=%0b, expected a=15 op=1 b=3 pulse=1",
                     operand_a, op_code, operand_b, exec_pulse);
        end
        press(8'h09);
        checks++;
        if (operand_a !== 8'd9 || operand_b !== 8'd0 || digit_count !== 2'd1 || sel_operand !== 1'b0 || op_code !== 2'b01) begin
            errors++;
            $display("FAIL fresh_entry: got a=%0d b=%0d cnt=%0d sel=%0b op=%0d, expected a=9 b=0 cnt=1 sel=0 op=1",
                     operand_a, operand_b, digit_count, sel_operand, op_code);
        end
    endtask

    task automatic test_op_replace_mem();
        press(8'h0F); press(8'h05); press(8'h0A); press(8'h0C);
        checks++;
        if (op_code !== 2'b10 || sel_operand !== 1'b1) begin
            errors++;
            $display("FAIL op_replace: got op=%0d sel=%0b, expected op=2 sel=1", op_code, sel_operand);
        end
        press(8'h0E);
        checks++;
        if (exec_pulse !== 1'b0 || sel_operand !== 1'b1) begin
            errors++;
            $display("FAIL equals_empty_b: got pulse=%0b sel=%0b, expected pulse=0 sel=1", exec_pulse, sel_operand);
        end
        mem_value = 8'd42;
        press(8'h10);
        checks++;
        if (operand_b !== 8'd42 || digit_count !== 2'd0) begin
            errors++;
            $display("FAIL mem_recall: got b=%0d cnt=%0d, expected b=42 cnt=0", operand_b, digit_count);
        end
        press(8'h01);
        checks++;
        if (operand_b !== 8'd42 || overflow_err !== 1'b1) begin
            errors++;
            $display("FAIL locked_digit: got b=%0d ovf=%0b, expected b=42 ovf=1", operand_b, overflow_err);
        end
        press(8'h0D);
        checks++;
        if (op_code !== 2'b10) begin
            errors++;
            $display("FAIL op_after_lock: got op=%0d, expected 2", op_code);
        end
        press(8'h0E);
        checks++;
        if (exec_pulse !== 1'b1) begin
            errors++;
            $display("FAIL equals_locked_b: got pulse=%0b, expected 1", exec_pulse);
        end
    endtask

    task automatic test_reset_midentry();
        press(8'h0F); press(8'h01); press(8'h02);
        checks++;
        if (operand_a !== 8'd12) begin
            errors++;
            $display("FAIL pre_reset_a: got %0d, expected 12", operand_a);
        end
        cycle(1'b0, 1'b1, 8'h03);
        checks++;
        if ({operand_a, operand_b, op_code, sel_operand, digit_count, exec_pulse, overflow_err} !== '0) begin
            errors++;
            $display("FAIL reset_midentry: got a=%0d b=%0d op=%0d sel=%0b cnt=%0d, expected all 0",
                     operand_a, operand_b, op_code, sel_operand, digit_count);
        end
        press(8'h04);
        checks++;
        if (operand_a !== 8'd4 || sel_operand !== 1'b0 || digit_count !== 2'd1) begin
            errors++;
            $display("FAIL after_reset_digit: got a=%0d sel=%0b cnt=%0d, expected a=4 sel=0 cnt=1",
                     operand_a, sel_operand, digit_count);
        end
    endtask

    task automatic test_random();
        logic [7:0] k;
        int unsigned r;
        bit kv, rr;
        cycle(1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 19);
            k = (r <= 16) ? 8'(r) : 8'($urandom_range(17, 255));
            kv = ($urandom_range(0, 3) != 0);
            rr = ($urandom_range(0, 63) != 0);
            mem_value = 8'($urandom_range(0, 255));
            result = 8'($urandom_range(0, 255));
            cycle(rr, kv, k);
            checks++;
            if (operand_a !== 8'(m_a) || operand_b !== 8'(m_b) || op_code !== 2'(m_op) ||
                sel_operand !== (m_phase == 1) || digit_count !== 2'(m_cnt) ||
                exec_pulse !== m_pulse || overflow_err !== m_ovf) begin
                errors++;
                $display("FAIL random_step%0d key=%h kv=%0b: got a=%0d b=%0d op=%0d sel=%0b cnt=%0d pulse=%0b ovf=%0b, expected a=%0d b=%0d op=%0d sel=%0b cnt=%0d pulse=%0b ovf=%0b",
                         i, k, kv, operand_a, operand_b, op_code, sel_operand, digit_count, exec_pulse, overflow_err,
                         m_a, m_b, m_op, (m_phase == 1), m_cnt, m_pulse, m_ovf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_digits();
        test_overflow();
        test_add_equals();
        test_chaining();
        test_op_replace_mem();
        test_reset_midentry();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
